gfp8_result_packer: RTL and testbench

//  Consumer end of the BCV controller result stream. Takes each GFP result (signed mantissa x 2^exponent)
//  and converts it to IEEE FP16. Packs RES_PER_LINE results into one output line and queues lines in a

---
 rtl/gfp8_pkg.sv | 29 ++
 rtl/gfp8_result_packer_gfp8_to_fp16.sv | 80 ++++++++
 rtl/gfp8_result_packer.sv | 139 +++++++++++++
 tb/tb_gfp8_result_packer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfp8_pkg.sv
// Shared types and constants for the GFP-to-FP16 result packer.
package gfp8_pkg;

  localparam int          FP16_BIAS       = 15;
  localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PACK      = 2'd1,
    ST_WAIT_LAST = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [31:0] mantissa;
    logic signed [7:0]  exponent;
  } gfp_result_t;

  // Index of the highest set bit; 0 for a zero input.
  function automatic logic [4:0] msb_pos(input logic [31:0] value);
    logic [4:0] pos;
    pos = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) pos = 5'(i);
      else          pos = pos;
    end
    return pos;
  endfunction

endpackage

// File: rtl/gfp8_result_packer_gfp8_to_fp16.sv
// Two-stage GFP (signed mantissa x 2^exponent) to FP16 converter with a
// valid/done sideband that travels alongside the data.
module gfp8_to_fp16
  import gfp8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic        in_done,
  input  gfp_result_t in_result,
  output logic        out_valid,
  output logic        out_done,
  output logic [15:0] out_fp16,
  output logic        busy
);

  logic               s1_valid, s1_done, s1_sign;
  logic [31:0]        s1_mag;
  logic [4:0]         s1_pos;
  logic signed [7:0]  s1_exp;
  logic [31:0]        mag_in, norm;
  logic [10:0]        rnd;
  logic signed [9:0]  e_biased, e_round;
  logic               guard, sticky;
  logic [15:0]        fp16_c;

  assign mag_in = in_result.mantissa[31] ? (32'd0 - in_result.mantissa) : in_result.mantissa;

  // Stage 1: sign, magnitude and leading-one position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_done <= 1'b0; s1_sign <= 1'b0;
      s1_mag <= 32'd0; s1_pos <= 5'd0; s1_exp <= 8'sd0;
    end else if (clear) begin
      s1_valid <= 1'b0; s1_done <= 1'b0; s1_sign <= 1'b0;
      s1_mag <= 32'd0; s1_pos <= 5'd0; s1_exp <= 8'sd0;
    end else begin
      s1_valid <= in_valid;
      s1_done  <= in_done;
      if (in_valid) begin
        s1_sign <= in_result.mantissa[31];
        s1_mag  <= mag_in;
        s1_pos  <= msb_pos(mag_in);
        s1_exp  <= in_result.exponent;
      end
    end
  end

  // Stage 2 datapath: normalise, round to nearest even, then range-limit.
  always_comb begin
    norm     = s1_mag << (5'd31 - s1_pos);
    guard    = norm[20];
    sticky   = |norm[19:0];
    rnd      = {1'b0, norm[30:21]} + {10'd0, guard & (sticky | norm[21])};
    e_biased = $signed({5'd0, s1_pos}) + $signed({{2{s1_exp[7]}}, s1_exp})
               + $signed(10'(FP16_BIAS));
    e_round  = e_biased + $signed({9'd0, rnd[10]});
    if (s1_mag == 32'd0)           fp16_c = 16'h0000;
    else if (e_round <= 10'sd0)    fp16_c = {s1_sign, 15'd0};
    else if (e_round >= 10'sd31)   fp16_c = {s1_sign, FP16_MAX_FINITE[14:0]};
    else                           fp16_c = {s1_sign, e_round[4:0], rnd[9:0]};
  end

  // Stage 2 output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; out_done <= 1'b0; out_fp16 <= 16'h0000;
    end else if (clear) begin
      out_valid <= 1'b0; out_done <= 1'b0; out_fp16 <= 16'h0000;
    end else begin
      out_valid <= s1_valid;
      out_done  <= s1_done;
      out_fp16  <= s1_valid ? fp16_c : out_fp16;
    end
  end

  assign busy = s1_valid | s1_done | out_valid | out_done;

endmodule

// File: rtl/gfp8_result_packer.sv
// Packs converted FP16 results into lines and queues them in a show-ahead
// FIFO; tile_done flushes the partial line and marks the tile's last line.
module gfp8_result_packer
  import gfp8_pkg::*;
#(
  parameter int RES_PER_LINE = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int LINE_W      = 16 * RES_PER_LINE,
  localparam int NRES_W      = $clog2(RES_PER_LINE + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_result_mantissa,
  input  logic [7:0]        i_result_exponent,
  input  logic              i_result_valid,
  input  logic              i_tile_done,
  input  logic              i_clear,
  output logic [LINE_W-1:0] o_line_data,
  output logic [NRES_W-1:0] o_line_nres,
  output logic              o_line_last,
  output logic              o_line_valid,
  input  logic              i_line_ready,
  output logic              o_tile_complete,
  output logic              o_overflow,
  output logic [15:0]       o_result_count,
  output logic              o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  gfp_result_t        result_in;
  logic               conv_valid, conv_done, conv_busy;
  logic [15:0]        conv_fp16;

  state_t             state_r, state_next, next_fill;
  logic [LINE_W-1:0]  line_r, line_w;
  logic [NRES_W-1:0]  cnt_r, cnt_w;
  logic [LINE_W-1:0]  mem_data [FIFO_DEPTH];
  logic [NRES_W-1:0]  mem_nres [FIFO_DEPTH];
  logic               mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   fifo_cnt_r;
  logic               overflow_r, tile_complete_r, new_tile_r;
  logic [15:0]        result_count_r;
  logic               push, pop, drop, push_ok, fifo_full, head_last, complete_next;

  assign result_in.mantissa = i_result_mantissa;
  assign result_in.exponent = i_result_exponent;

  gfp8_to_fp16 u_conv (
    .clk       (i_clk),
    .rst       (i_reset),
    .clear     (i_clear),
    .in_valid  (i_result_valid),
    .in_done   (i_tile_done),
    .in_result (result_in),
    .out_valid (conv_valid),
    .out_done  (conv_done),
    .out_fp16  (conv_fp16),
    .busy      (conv_busy)
  );

  // Slot write, line push/drop decisions and next packer state.
  always_comb begin
    line_w = line_r;
    for (int k = 0; k < RES_PER_LINE; k++) begin
      if (conv_valid && (cnt_r == NRES_W'(k))) line_w[16*k +: 16] = conv_fp16;
      else                                     line_w[16*k +: 16] = line_r[16*k +: 16];
    end
    cnt_w         = conv_valid ? (cnt_r + NRES_W'(1)) : cnt_r;
    push          = (cnt_w == NRES_W'(RES_PER_LINE)) || (conv_done && (cnt_w != NRES_W'(0)));
    pop           = o_line_valid && i_line_ready;
    fifo_full     = (fifo_cnt_r == CNT_W'(FIFO_DEPTH));
    drop          = push && fifo_full && !pop;
    push_ok       = push && !drop;
    head_last     = mem_last[rd_ptr_r];
    // A tile with nothing left to send, or whose last line was dropped, completes at once.
    complete_next = (pop && head_last) || (conv_done && !push) || (drop && conv_done);
    next_fill     = (push || (cnt_w == NRES_W'(0))) ? ST_IDLE : ST_PACK;
    if (conv_done) begin
      state_next = push_ok ? ST_WAIT_LAST : ST_IDLE;
    end else begin
      case (state_r)
        ST_WAIT_LAST:     state_next = (pop && head_last) ? next_fill : ST_WAIT_LAST;
        ST_IDLE, ST_PACK: state_next = next_fill;
        default:          state_next = ST_IDLE;
      endcase
    end
  end

  // Packer, FIFO pointers and status registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE; line_r <= '0; cnt_r <= NRES_W'(0);
      wr_ptr_r <= PTR_W'(0); rd_ptr_r <= PTR_W'(0); fifo_cnt_r <= CNT_W'(0);
      overflow_r <= 1'b0; tile_complete_r <= 1'b0; new_tile_r <= 1'b0; result_count_r <= 16'd0;
    end else if (i_clear) begin
      state_r <= ST_IDLE; line_r <= '0; cnt_r <= NRES_W'(0);
      wr_ptr_r <= PTR_W'(0); rd_ptr_r <= PTR_W'(0); fifo_cnt_r <= CNT_W'(0);
      overflow_r <= 1'b0; tile_complete_r <= 1'b0; new_tile_r <= 1'b0; result_count_r <= 16'd0;
    end else begin
      state_r         <= state_next;
      line_r          <= push ? '0 : line_w;
      cnt_r           <= push ? NRES_W'(0) : cnt_w;
      wr_ptr_r        <= push_ok ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
      rd_ptr_r        <= pop ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
      case ({push_ok, pop})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      overflow_r      <= overflow_r | drop;
      tile_complete_r <= complete_next;
      // The result that arrives with done still belongs to the closing tile.
      if (conv_valid) result_count_r <= new_tile_r ? 16'd1 : (result_count_r + 16'd1);
      new_tile_r      <= conv_done ? 1'b1 : (conv_valid ? 1'b0 : new_tile_r);
    end
  end

  // Line storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_data[wr_ptr_r] <= line_w;
      mem_nres[wr_ptr_r] <= cnt_w;
      mem_last[wr_ptr_r] <= conv_done;
    end
  end

  assign o_line_valid    = (fifo_cnt_r != CNT_W'(0));
  assign o_line_data     = o_line_valid ? mem_data[rd_ptr_r] : '0;
  assign o_line_nres     = o_line_valid ? mem_nres[rd_ptr_r] : NRES_W'(0);
  assign o_line_last     = o_line_valid && mem_last[rd_ptr_r];
  assign o_tile_complete = tile_complete_r;
  assign o_overflow      = overflow_r;
  assign o_result_count  = result_count_r;
  assign o_busy          = conv_busy || (cnt_r != NRES_W'(0)) || o_line_valid;

endmodule

// File: tb/tb_gfp8_result_packer.sv
// Randomised self-checking bench for gfp8_result_packer against a
// real-arithmetic FP16 reference and a queue-based line packing model.
module tb_gfp8_result_packer;

  localparam int RPL = 16;
  localparam int LW  = 16 * RPL;

  logic          clk = 1'b0;
  logic          rst, clear, valid, done, ready;
  logic [31:0]   mant;
  logic [7:0]    expo;
  logic [LW-1:0] o_line_data;
  logic [4:0]    o_line_nres;
  logic          o_line_last, o_line_valid, o_tile_complete, o_overflow, o_busy;
  logic [15:0]   o_result_count;

  typedef struct {
    logic [LW-1:0] data;
    int            nres;
    bit            last;
  } line_t;

  line_t       obs_q[$], exp_q[$];
  logic [15:0] cur_q[$];
  int total = 0, bad = 0, cycle = 0, tc_count = 0, tc_cycle = -1, hs_last_cycle = -2, dones = 0;

  always #5 clk = ~clk;

  gfp8_result_packer #(.RES_PER_LINE(RPL), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_result_mantissa(mant), .i_result_exponent(expo),
    .i_result_valid(valid), .i_tile_done(done), .i_clear(clear),
    .o_line_data(o_line_data), .o_line_nres(o_line_nres), .o_line_last(o_line_last),
    .o_line_valid(o_line_valid), .i_line_ready(ready), .o_tile_complete(o_tile_complete),
    .o_overflow(o_overflow), .o_result_count(o_result_count), .o_busy(o_busy)
  );

  // Exact value m*2^e as a real, rounded to 11 significant bits (ties to even).
  function automatic logic [15:0] ref_fp16(input int m, input int e);
    longint mag;
    real    a, sc, rem;
    int     ex, be;
    longint r;
    logic   s;
    if (m == 0) return 16'h0000;
    s   = (m < 0);
    mag = (m < 0) ? -longint'(m) : longint'(m);
    a   = real'(mag);
    ex  = 0;
    while (a >= 2.0) begin a = a / 2.0; ex++; end
    ex  = ex + e;
    sc  = a * 1024.0;
    r   = $rtoi(sc);
    rem = sc - real'(r);
    if (rem > 0.5 || (rem == 0.5 && (r % 2) == 1)) r++;
    if (r == 2048) begin r = 1024; ex++; end
    be = ex + 15;
    if (be <= 0)  return {s, 15'd0};
    if (be >= 31) return {s, 15'h7BFF};
    return {s, be[4:0], r[9:0]};
  endfunction

  task automatic model_step(input bit v, input int m, input int e, input bit d);
    line_t l;
    if (v) cur_q.push_back(ref_fp16(m, e));
    if (cur_q.size() == RPL || (d && cur_q.size() > 0)) begin
      l.data = '0;
      for (int k = 0; k < cur_q.size(); k++) l.data[16*k +: 16] = cur_q[k];
      l.nres = cur_q.size();
      l.last = d;
      exp_q.push_back(l);
      cur_q.delete();
    end
    if (d) dones++;
  endtask

  task automatic tick();
    line_t l;
    if (o_line_valid && ready) begin
      l.data = o_line_data; l.nres = int'(o_line_nres); l.last = o_line_last;
      obs_q.push_back(l);
      if (o_line_last) hs_last_cycle = cycle + 1;
    end
    @(posedge clk); #1;
    cycle++;
    if (o_tile_complete) begin tc_count++; tc_cycle = cycle; end
  endtask

  task automatic drive(input bit v, input int m, input int e, input bit d);
    valid = v; done = d; mant = 32'(m); expo = 8'(e);
    model_step(v, m, e, d);
    tick();
    valid = 1'b0; done = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((o_busy || o_line_valid) && n < 500) begin tick(); n++; end
    tick(); tick();
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL %s_drain: busy=%b after %0d cycles, want 0", name, o_busy, n);
    end
  endtask

  function automatic int rand_mant();
    int m;
    m = int'($urandom >> $urandom_range(0, 31));
    if ($urandom_range(0, 1) == 1) m = -m;
    return m;
  endfunction

  task automatic reset_queues();
    obs_q.delete(); exp_q.delete(); tc_count = 0; dones = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++;
    if ({o_line_valid, o_line_last, o_tile_complete, o_overflow, o_busy} !== 5'd0) begin
      bad++; $display("FAIL reset_flags: got %b, want 00000", {o_line_valid, o_line_last, o_tile_complete, o_overflow, o_busy});
    end
    total++;
    if (o_line_data !== '0 || o_line_nres !== 5'd0 || o_result_count !== 16'd0) begin
      bad++; $display("FAIL reset_values: data=%h nres=%0d count=%0d, want all 0", o_line_data, o_line_nres, o_result_count);
    end
    rst = 1'b0; tick(); tick();
    total++;
    if (o_line_valid !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: valid=%b busy=%b, want 0 0", o_line_valid, o_busy);
    end
  endtask

  task automatic test_conversion();
    int          dm [10] = '{1, -3, 0, 2047, 4095, 1, 1, -1, 1, -1};
    int          de [10] = '{0, -1, 5, 0, 0, 15, 16, 16, -15, -25};
    logic [15:0] dx [10] = '{16'h3C00, 16'hBE00, 16'h0000, 16'h67FF, 16'h6C00,
                             16'h7800, 16'h7BFF, 16'hFBFF, 16'h0000, 16'h8000};
    reset_queues(); ready = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b1, dm[i], de[i], 1'b1);
    for (int i = 0; i < 40; i++) drive(1'b1, rand_mant(), $urandom_range(0, 60) - 30, 1'b1);
    drive(1'b1, 32'h8000_0000, -20, 1'b1);
    drain("conv");
    for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data[15:0] !== dx[i] || obs_q[i].nres != 1 || obs_q[i].last != 1'b1) begin
        bad++; $display("FAIL conv_directed%0d: got %h nres=%0d last=%0d, want %h nres=1 last=1",
                        i, obs_q[i].data[15:0], obs_q[i].nres, obs_q[i].last, dx[i]);
      end
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL conv_count: got %0d lines, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].nres != exp_q[i].nres || obs_q[i].last != exp_q[i].last) begin
        bad++; $display("FAIL conv_line%0d: got %h, want %h", i, obs_q[i].data[15:0], exp_q[i].data[15:0]);
      end
    end
  endtask

  task automatic test_tile6();
    reset_queues(); ready = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, rand_mant(), $urandom_range(0, 20) - 10, i == 5);
    tick();
    total++;
    if (o_line_valid !== 1'b0) begin bad++; $display("FAIL tile6_latency_early: valid=%b, want 0", o_line_valid); end
    tick();
    total++;
    if (o_line_valid !== 1'b1) begin bad++; $display("FAIL tile6_latency: valid=%b, want 1", o_line_valid); end
    total++;
    if (o_line_data[LW-1:96] !== '0 || o_line_nres !== 5'd6 || o_line_last !== 1'b1) begin
      bad++; $display("FAIL tile6_head: upper=%h nres=%0d last=%b, want 0 6 1", o_line_data[LW-1:96], o_line_nres, o_line_last);
    end
    drain("tile6");
    total++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0].data !== exp_q[0].data) begin
      bad++; $display("FAIL tile6_line: got %0d lines, want 1 with data %h", obs_q.size(), exp_q[0].data[95:0]);
    end
    total++;
    if (tc_count != 1 || tc_cycle != hs_last_cycle) begin
      bad++; $display("FAIL tile6_complete: pulses=%0d at cycle %0d, want 1 at cycle %0d", tc_count, tc_cycle, hs_last_cycle);
    end
    total++;
    if (o_result_count !== 16'd6) begin bad++; $display("FAIL tile6_count: got %0d, want 6", o_result_count); end
  endtask

  task automatic test_two_lines();
    reset_queues(); ready = 1'b1;
    for (int i = 0; i < 32; i++) drive(1'b1, rand_mant(), $urandom_range(0, 20) - 10, i == 31);
    drain("two");
    total++;
    if (obs_q.size() != 2) begin
      bad++; $display("FAIL two_count: got %0d lines, want 2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0].nres != 16 || obs_q[0].last || obs_q[1].nres != 16 || !obs_q[1].last) begin
        bad++; $display("FAIL two_flags: got nres=%0d/%0d last=%0d/%0d, want 16/16 0/1",
                        obs_q[0].nres, obs_q[1].nres, obs_q[0].last, obs_q[1].last);
      end
      total++;
      if (obs_q[0].data !== exp_q[0].data || obs_q[1].data !== exp_q[1].data) begin
        bad++; $display("FAIL two_data: got %h, want %h", obs_q[1].data, exp_q[1].data);
      end
    end
  endtask

  task automatic test_overflow();
    reset_queues(); ready = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, rand_mant(), $urandom_range(0, 20) - 10, i == 19);
    repeat (4) tick();
    total++;
    if (o_overflow !== 1'b0 || o_line_valid !== 1'b1) begin
      bad++; $display("FAIL ovf_before: overflow=%b valid=%b, want 0 1", o_overflow, o_line_valid);
    end
    for (int i = 0; i < 60; i++) drive(1'b1, rand_mant(), $urandom_range(0, 20) - 10, 1'b0);
    repeat (4) tick();
    total++;
    if (o_overflow !== 1'b1 || o_result_count !== 16'd60) begin
      bad++; $display("FAIL ovf_after: overflow=%b count=%0d, want 1 60", o_overflow, o_result_count);
    end
    if (exp_q.size() > 4) exp_q.delete(4);
    ready = 1'b1;
    repeat (6) tick();
    total++;
    if (obs_q.size() != 4) begin bad++; $display("FAIL ovf_drain: got %0d lines, want 4", obs_q.size()); end
    drive(1'b0, 0, 0, 1'b1);
    drain("ovf");
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL ovf_count: got %0d lines, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].nres != exp_q[i].nres || obs_q[i].last != exp_q[i].last) begin
        bad++; $display("FAIL ovf_line%0d: got nres=%0d last=%0d, want nres=%0d last=%0d",
                        i, obs_q[i].nres, obs_q[i].last, exp_q[i].nres, exp_q[i].last);
      end
    end
    total++;
    if (tc_count != 2) begin bad++; $display("FAIL ovf_complete: got %0d pulses, want 2", tc_count); end
  endtask

  task automatic test_clear();
    reset_queues(); ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, rand_mant(), 0, 1'b0);
    repeat (3) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    cur_q.delete();
    total++;
    if ({o_overflow, o_busy, o_line_valid} !== 3'b000 || o_result_count !== 16'd0) begin
      bad++; $display("FAIL clear_state: ovf/busy/valid=%b count=%0d, want 000 0", {o_overflow, o_busy, o_line_valid}, o_result_count);
    end
  endtask

  task automatic test_reset_mid();
    reset_queues(); ready = 1'b0;
    for (int i = 0; i < 23; i++) drive(1'b1, rand_mant(), 0, 1'b0);
    repeat (3) tick();
    total++;
    if (o_line_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre: valid=%b, want 1", o_line_valid); end
    ready = 1'b1; #1; rst = 1'b1; #1;
    total++;
    if ({o_line_valid, o_line_last, o_tile_complete, o_overflow, o_busy} !== 5'd0 ||
        o_line_data !== '0 || o_line_nres !== 5'd0 || o_result_count !== 16'd0) begin
      bad++; $display("FAIL rmid_zero: flags=%b nres=%0d count=%0d, want all 0",
                      {o_line_valid, o_line_last, o_tile_complete, o_overflow, o_busy}, o_line_nres, o_result_count);
    end
    tick(); tick(); rst = 1'b0;
    cur_q.delete(); reset_queues();
    tick();
    for (int i = 0; i < 3; i++) drive(1'b1, rand_mant(), $urandom_range(0, 10), i == 2);
    drain("rmid");
    total++;
    if (obs_q.size() != 1 || obs_q[0].nres != 3 || obs_q[0].data !== exp_q[0].data) begin
      bad++; $display("FAIL rmid_line: got %0d lines nres=%0d, want 1 line nres=3 data %h",
                      obs_q.size(), (obs_q.size() > 0) ? obs_q[0].nres : -1, exp_q[0].data[47:0]);
    end
  endtask

  task automatic test_random();
    int len;
    int last_len = 0;
    reset_queues();
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(1, 40);
      last_len = len;
      for (int i = 0; i < len; i++) begin
        ready = ($urandom_range(0, 3) != 0);
        while ($urandom_range(0, 4) == 0) drive(1'b0, 0, 0, 1'b0);
        drive(1'b1, rand_mant(), $urandom_range(0, 80) - 40, i == len - 1);
      end
    end
    ready = 1'b1;
    drain("rand");
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count: got %0d lines, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].nres != exp_q[i].nres || obs_q[i].last != exp_q[i].last) begin
        bad++; $display("FAIL rand_line%0d: got nres=%0d last=%0d data=%h, want nres=%0d last=%0d data=%h",
                        i, obs_q[i].nres, obs_q[i].last, obs_q[i].data, exp_q[i].nres, exp_q[i].last, exp_q[i].data);
      end
    end
    total++;
    if (tc_count != dones || o_overflow !== 1'b0) begin
      bad++; $display("FAIL rand_tiles: pulses=%0d overflow=%b, want %0d 0", tc_count, o_overflow, dones);
    end
    total++;
    if (o_result_count !== 16'(last_len)) begin
      bad++; $display("FAIL rand_result_count: got %0d, want %0d", o_result_count, last_len);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; valid = 1'b0; done = 1'b0; ready = 1'b1;
    mant = 32'd0; expo = 8'd0;
    test_reset();
    test_conversion();
    test_tile6();
    test_two_lines();
    test_overflow();
    test_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
